// File: rtl/dsd_pkg.sv
// Shared definitions for the single-wire serial link: transmitter state
// encoding and idle line level, also used by the matching receiver.
package dsd_pkg;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = TX_IDLE,
    ST_START  = TX_START,
    ST_DATA   = TX_DATA,
    ST_PARITY = TX_PARITY,
    ST_STOP   = TX_STOP
  } tx_state_e;

endpackage

// File: rtl/piso_frame_tx_if.sv
// Word handshake between a parallel source and the frame transmitter.
interface piso_frame_tx_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] DATA_IN;
  logic             VALID;
  logic             READY;

  modport master (output DATA_IN, output VALID, input READY);
  modport slave  (input DATA_IN, input VALID, output READY);

endinterface

// File: rtl/bit_timer.sv
// Bit-period timer: TICK marks the last CLK cycle of each bit while enabled.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while disabled so a new frame always starts a full bit period.
  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter: idle-high line, start bit,
// data LSB first, optional even parity, stop bit.
module piso_frame_tx
  import dsd_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic           CLK,
  input  logic           RST,
  piso_frame_tx_if.slave bus,
  output logic           Q,
  output logic           BUSY,
  output logic           DONE
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  tx_state_e        state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic             par, par_nx;
  logic             q_nx;
  logic             tick;
  logic             accept;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK (CLK),
    .RST (RST),
    .EN  (state != ST_IDLE),
    .TICK(tick)
  );

  assign accept    = (state == ST_IDLE) && bus.VALID;
  assign bus.READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign DONE      = (state == ST_STOP) && tick;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    idx_nx   = idx;
    par_nx   = par;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_START;
          shreg_nx = bus.DATA_IN;
          par_nx   = ^bus.DATA_IN;
          idx_nx   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_nx = shreg >> 1;
          if (idx == LAST_IDX) begin
            idx_nx   = '0;
            state_nx = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Line level follows the next state so Q changes on the same edge as the state.
    q_nx = LINE_IDLE;
    case (state_nx)
      ST_START:  q_nx = 1'b0;
      ST_DATA:   q_nx = shreg_nx[0];
      ST_PARITY: q_nx = par_nx;
      default:   q_nx = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      shreg <= '0;
      idx   <= '0;
      par   <= 1'b0;
      Q     <= LINE_IDLE;
    end else begin
      state <= state_nx;
      shreg <= shreg_nx;
      idx   <= idx_nx;
      par   <= par_nx;
      Q     <= q_nx;
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench for piso_frame_tx: three configurations share one stimulus
// stream; each test observes the instance it targets.
module tb_piso_frame_tx;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [7:0] din;
  int         sel;
  int         n_chk;
  int         n_err;

  logic q_a, busy_a, done_a;
  logic q_b, busy_b, done_b;
  logic q_c, busy_c, done_c;
  logic q_o, busy_o, done_o, ready_o;

  piso_frame_tx_if #(.WIDTH(8)) if_a ();
  piso_frame_tx_if #(.WIDTH(8)) if_b ();
  piso_frame_tx_if #(.WIDTH(8)) if_c ();

  assign if_a.VALID   = valid;
  assign if_a.DATA_IN = din;
  assign if_b.VALID   = valid;
  assign if_b.DATA_IN = din;
  assign if_c.VALID   = valid;
  assign if_c.DATA_IN = din;

  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) u_a (
    .CLK(clk), .RST(rst), .bus(if_a), .Q(q_a), .BUSY(busy_a), .DONE(done_a)
  );
  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) u_b (
    .CLK(clk), .RST(rst), .bus(if_b), .Q(q_b), .BUSY(busy_b), .DONE(done_b)
  );
  piso_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1'b1)) u_c (
    .CLK(clk), .RST(rst), .bus(if_c), .Q(q_c), .BUSY(busy_c), .DONE(done_c)
  );

  always_comb begin
    q_o = q_a; busy_o = busy_a; done_o = done_a; ready_o = if_a.READY;
    if (sel == 1) begin
      q_o = q_b; busy_o = busy_b; done_o = done_b; ready_o = if_b.READY;
    end else if (sel == 2) begin
      q_o = q_c; busy_o = busy_c; done_o = done_c; ready_o = if_c.READY;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_all();
    rst = 1'b1;
    valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk({tag, "_q"}, q_o, 1);
      chk({tag, "_ready"}, ready_o, 1);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
    end
  endtask

  // Called just after the accept edge; checks every cycle of one frame.
  task automatic watch(input string tag, input logic [15:0] bits, input int nb,
                       input int c, input bit scramble);
    for (int k = 0; k < nb * c; k++) begin
      if (k > 0) step();
      if (scramble) din = 8'($urandom);
      chk({tag, "_q"}, q_o, bits[k / c]);
      chk({tag, "_done"}, done_o, (k == nb * c - 1));
      chk({tag, "_ready"}, ready_o, 0);
      chk({tag, "_busy"}, busy_o, 1);
    end
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic [15:0] bits,
                      input int nb, input int c);
    valid = 1'b1;
    din   = d;
    step();
    valid = 1'b0;
    watch(tag, bits, nb, c, 1'b1);
    step();
    chk({tag, "_end_ready"}, ready_o, 1);
    chk({tag, "_end_q"}, q_o, 1);
    chk({tag, "_end_done"}, done_o, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    sel   = 0;
    rst   = 1'b1;
    valid = 1'b1;
    din   = 8'hA5;

    // Reset held three cycles with VALID high
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("reset");
    end
    rst   = 1'b0;
    valid = 1'b0;
    step();
    chk_idle("post_reset");

    // Single frame 0xA5: start, 10100101 LSB first, parity 0, stop
    rst_all();
    sel = 0;
    send("a5", 8'hA5, 16'b1_0_10100101_0, 11, 4);

    // Parity disabled, 0x07
    rst_all();
    sel = 1;
    send("nopar", 8'h07, 16'b1_00000111_0, 10, 4);

    // Back-to-back 0xFF then 0x00 with VALID held
    rst_all();
    sel   = 0;
    valid = 1'b1;
    din   = 8'hFF;
    step();
    din = 8'h00;
    watch("b2b_ff", 16'b1_0_11111111_0, 11, 4, 1'b0);
    step();
    chk("b2b_gap_q", q_o, 1);
    chk("b2b_gap_ready", ready_o, 1);
    chk("b2b_gap_done", done_o, 0);
    step();
    valid = 1'b0;
    watch("b2b_00", 16'b1_0_00000000_0, 11, 4, 1'b0);
    step();
    chk("b2b_end_ready", ready_o, 1);
    step();
    chk("b2b_idle_ready", ready_o, 1);
    chk("b2b_idle_q", q_o, 1);

    // Abort during data bit 3 of 0xA5 (bit 3 is 0)
    rst_all();
    sel   = 0;
    valid = 1'b1;
    din   = 8'hA5;
    step();
    valid = 1'b0;
    for (int k = 1; k <= 16; k++) step();
    chk("abort_pre_q", q_o, 0);
    chk("abort_pre_busy", busy_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_q", q_o, 1);
    chk("abort_ready", ready_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    for (int k = 0; k < 30; k++) begin
      step();
      chk("abort_quiet_done", done_o, 0);
      chk("abort_quiet_q", q_o, 1);
    end
    send("3c", 8'h3C, 16'b1_0_00111100_0, 11, 4);

    // One cycle per bit, 0x80 with DATA_IN scrambled after accept
    rst_all();
    sel = 2;
    send("min", 8'h80, 16'b1_1_10000000_0, 11, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
# piso_frame_tx

Parallel-in/serial-out frame transmitter. It is the launching end of the team's single-wire serial link, whose receiving end captures the line on the falling edge of `CLK`. All logic runs on the rising edge of `CLK`, so each line transition lands half a cycle before the receiver samples it. A parallel word is accepted through a VALID/READY handshake and sent as an idle-high frame: start bit, data bits LSB first, optional even-parity bit, then stop bit.

## Interface
- `WIDTH`, 8: data bits per frame, ≥2.
- `CLKS_PER_BIT`, 4: `CLK` cycles each bit is held on `Q`, ≥1.
- `PARITY_EN`, 1: 1 appends an even-parity bit; 0 omits it.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `DATA_IN` in `WIDTH`: word to send; sampled only on the accept edge.
- `VALID` in 1: source has a word.
- `READY` out 1: block can accept a word.
- `Q` out 1: serial line, registered, idles at 1.
- `BUSY` out 1: frame in progress (equals `~READY`).
- `DONE` out 1: one-cycle pulse during the final cycle of the stop bit.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on `VALID && READY`.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY, or → STOP if `PARITY_EN=0`, after `WIDTH` bits.
  - PARITY → STOP.
  - STOP → IDLE.
- Line value per state: IDLE 1; START 0; DATA `shreg[0]`; PARITY XOR of the latched word; STOP 1.
- On the accept edge, `DATA_IN` is copied into the shift register. Later changes on `DATA_IN` are ignored until the next accept.
- Bit timer counts 0..`CLKS_PER_BIT`-1. The bit advances when the count wraps.
- The bit index counts 0..`WIDTH`-1 and the shift register shifts right once per data bit.
- Frame length is F = `WIDTH`+2+`PARITY_EN` bits, which is F·`CLKS_PER_BIT` cycles.
- Counter widths are `$clog2` of their range, minimum 1 bit. `CLKS_PER_BIT=1` means every cycle is a bit boundary.

Reset and boundary conditions:
- `RST` has priority over everything, including a simultaneous `VALID`.
- On the edge where `RST` is sampled high:
  - state = IDLE, `Q`=1, `READY`=1, `BUSY`=0, `DONE`=0;
  - counters and shift register are cleared.
- `RST` mid-frame aborts the frame. `Q` returns to 1 on that edge and `DONE` is not pulsed.
- `VALID` while `READY`=0 is ignored. No accept happens and nothing is buffered.
- `VALID` held high continuously sends back-to-back frames, with exactly one idle-high cycle between the stop bit and the next start bit.
- `VALID` may drop at any time. Only the accept edge matters.

## Timing
- Let the accept edge be t0.
- `Q` is 0 (start bit) from t0 to t0+C, where C = `CLKS_PER_BIT`.
- Data bit i is on `Q` from t0+C(1+i) to t0+C(2+i).
- Parity bit, if enabled, starts at t0+C(1+`WIDTH`).
- Stop bit starts at t0+C(F−1).
- `DONE`=1 for the single cycle ending at edge t0+C·F.
- `READY` is 1 and the state is IDLE from edge t0+C·F.
- The earliest next accept is edge t0+C·F+1.
- `READY` and `BUSY` change only on edges: `READY` falls at t0 and rises at t0+C·F.
- Latency from accept to start bit on `Q` is 0 cycles; it appears on the same edge.

## Structure
- Shared package `dsd_pkg` holds the state encoding as localparams (`TX_IDLE`..`TX_STOP`, 3 bits) and the idle line level constant `LINE_IDLE`=1. The matching receiver uses both.
- One sub-module, `bit_timer`: parameter `CLKS_PER_BIT`, inputs `CLK`/`RST`/`EN`, output `TICK` pulsed on the last cycle of each bit period. It is reused by the receiver.
- FSM, shift register, bit index and parity all stay in `piso_frame_tx`.

## Test plan
All cases use `WIDTH`=8, `CLKS_PER_BIT`=4, `PARITY_EN`=1 unless stated.
- **Reset:** hold `RST`=1 for 3 cycles with `VALID`=1 → `Q`=1, `READY`=1, `BUSY`=0, `DONE`=0 throughout, and no frame starts.
- **Single frame:** send 0xA5 → `Q` bits are 0,1,0,1,0,0,1,0,1,0,1, each held exactly 4 cycles (44 total). `DONE` is high only in cycle 44 and `READY` rises at edge t0+44.
- **Parity disabled:** `PARITY_EN`=0, send 0x07 → `Q` bits are 0,1,1,1,0,0,0,0,0,1 (40 cycles), with no parity slot.
- **Back-to-back:** hold `VALID`=1 with 0xFF then 0x00 → second start bit begins at t0+45, and `Q`=1 for exactly cycle 45. Parity bits are 0 and 0.
- **Abort:** assert `RST` for 1 cycle at t0+17 (during data bit 3) → `Q`=1 from that edge, no `DONE`, `READY`=1. A new `VALID` with 0x3C is then sent correctly.
- **Minimum timing:** `CLKS_PER_BIT`=1, send 0x80 → `Q` bits are 0,0,0,0,0,0,0,0,1,1,1, one cycle each. `DONE` is in cycle 11 and `DATA_IN` changes after t0 have no effect.
